// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared widths, ALU operation codes, pipeline stall levels and
//               FSM state encodings for the MEM-stage load/store unit.
//               There are no ports. The package supplies:
//                 - bus widths: register, register address and ALU op code
//                 - the load/store ALU op codes
//                 - Stop/NoStop stall levels, ZeroWord and NOPRegAddr
//                 - the load/store FSM state type
//                 - is_load / is_store decode helpers
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam int c_reg_bus      = 32;
    localparam int c_reg_addr_bus = 5;
    localparam int c_aluop_bus    = 8;

    localparam logic [c_aluop_bus-1:0] c_aluop_lb  = 8'b1110_0000;
    localparam logic [c_aluop_bus-1:0] c_aluop_lh  = 8'b1110_0001;
    localparam logic [c_aluop_bus-1:0] c_aluop_lw  = 8'b1110_0011;
    localparam logic [c_aluop_bus-1:0] c_aluop_lbu = 8'b1110_0100;
    localparam logic [c_aluop_bus-1:0] c_aluop_lhu = 8'b1110_0101;
    localparam logic [c_aluop_bus-1:0] c_aluop_sb  = 8'b1110_1000;
    localparam logic [c_aluop_bus-1:0] c_aluop_sh  = 8'b1110_1001;
    localparam logic [c_aluop_bus-1:0] c_aluop_sw  = 8'b1110_1011;

    localparam logic c_stop    = 1'b1;
    localparam logic c_no_stop = 1'b0;

    localparam logic [c_reg_bus-1:0]      c_zero_word    = 32'h0000_0000;
    localparam logic [c_reg_addr_bus-1:0] c_nop_reg_addr = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [c_aluop_bus-1:0] op);
        return (op == c_aluop_lb) || (op == c_aluop_lbu) || (op == c_aluop_lh) ||
               (op == c_aluop_lhu) || (op == c_aluop_lw);
    endfunction

    function automatic logic is_store(input logic [c_aluop_bus-1:0] op);
        return (op == c_aluop_sb) || (op == c_aluop_sh) || (op == c_aluop_sw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational big-endian lane logic for the load/store unit.
//               Produces the byte-lane select and the replicated store data
//               from the address and op code. Produces the sign- or
//               zero-extended load result from the buffered read word.
// Ports       : aluop      in  operation code
//               addr_lo    in  address bits 1:0
//               reg2       in  store source register
//               rd_buf     in  buffered bus read word
//               sel        out byte-lane select (bit 3 = bits 31:24)
//               store_data out lane-replicated store word
//               load_data  out extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [c_aluop_bus-1:0] aluop,
    input  logic [1:0]             addr_lo,
    input  logic [c_reg_bus-1:0]   reg2,
    input  logic [c_reg_bus-1:0]   rd_buf,
    output logic [3:0]             sel,
    output logic [c_reg_bus-1:0]   store_data,
    output logic [c_reg_bus-1:0]   load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian: offset 0 is the most significant byte of the word.
    always_comb begin
        w_byte = rd_buf[31:24];
        case (addr_lo)
            2'b00:   w_byte = rd_buf[31:24];
            2'b01:   w_byte = rd_buf[23:16];
            2'b10:   w_byte = rd_buf[15:8];
            default: w_byte = rd_buf[7:0];
        endcase
        w_half = addr_lo[1] ? rd_buf[15:0] : rd_buf[31:16];
    end

    always_comb begin
        sel        = 4'b0000;
        store_data = reg2;
        load_data  = c_zero_word;
        case (aluop)
            c_aluop_lb:  begin sel = 4'b1000 >> addr_lo; load_data = {{24{w_byte[7]}}, w_byte}; end
            c_aluop_lbu: begin sel = 4'b1000 >> addr_lo; load_data = {24'h0, w_byte}; end
            c_aluop_lh:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; load_data = {{16{w_half[15]}}, w_half}; end
            c_aluop_lhu: begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; load_data = {16'h0, w_half}; end
            c_aluop_lw:  begin sel = 4'b1111; load_data = rd_buf; end
            c_aluop_sb:  begin sel = 4'b1000 >> addr_lo; store_data = {4{reg2[7:0]}}; end
            c_aluop_sh:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; store_data = {2{reg2[15:0]}}; end
            c_aluop_sw:  begin sel = 4'b1111; store_data = reg2; end
            default:     ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : MEM pipeline stage with a single-outstanding load/store bus
//               master. Non-memory ops pass straight through to mem_wb.
//               Memory ops run IDLE -> BUSY -> HOLD. stallreq is raised while
//               the transfer is pending.
// Ports       : clk, rst (async, active-low)
//               EX/MEM inputs : wd_i, wreg_i, wdata_i, hi_i, lo_i, whilo_i,
//                               aluop_i, mem_addr_i, reg2_i
//               stall         : pipeline stall vector, bit 4 = MEM
//               bus slave     : bus_rdata, bus_ack
//               to mem_wb     : mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo,
//                               mem_whilo
//               to controller : stallreq
//               bus master    : bus_req, bus_we, bus_addr, bus_sel, bus_wdata
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [c_reg_addr_bus-1:0] wd_i,
    input  logic                      wreg_i,
    input  logic [c_reg_bus-1:0]      wdata_i,
    input  logic [c_reg_bus-1:0]      hi_i,
    input  logic [c_reg_bus-1:0]      lo_i,
    input  logic                      whilo_i,
    input  logic [c_aluop_bus-1:0]    aluop_i,
    input  logic [c_reg_bus-1:0]      mem_addr_i,
    input  logic [c_reg_bus-1:0]      reg2_i,
    input  logic [5:0]                stall,
    input  logic [c_reg_bus-1:0]      bus_rdata,
    input  logic                      bus_ack,
    output logic [c_reg_bus-1:0]      mem_wdata,
    output logic [c_reg_addr_bus-1:0] mem_wd,
    output logic                      mem_wreg,
    output logic [c_reg_bus-1:0]      mem_hi,
    output logic [c_reg_bus-1:0]      mem_lo,
    output logic                      mem_whilo,
    output logic                      stallreq,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [c_reg_bus-1:0]      bus_addr,
    output logic [3:0]                bus_sel,
    output logic [c_reg_bus-1:0]      bus_wdata
);

    lsu_state_t            r_state;
    lsu_state_t            w_state_nxt;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [c_reg_bus-1:0]  r_bus_addr;
    logic [3:0]            r_bus_sel;
    logic [c_reg_bus-1:0]  r_bus_wdata;
    logic [c_reg_bus-1:0]  r_rd_buf;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_mem;
    logic                  w_stallreq;
    logic [3:0]            w_sel;
    logic [c_reg_bus-1:0]  w_store_data;
    logic [c_reg_bus-1:0]  w_load_data;
    logic                  w_unused_stall;

    assign w_is_load      = is_load(aluop_i);
    assign w_is_store     = is_store(aluop_i);
    assign w_is_mem       = w_is_load | w_is_store;
    assign w_unused_stall = ^{stall[5], stall[3:0]};

    lsu_align u_align (
        .aluop      (aluop_i),
        .addr_lo    (mem_addr_i[1:0]),
        .reg2       (reg2_i),
        .rd_buf     (r_rd_buf),
        .sel        (w_sel),
        .store_data (w_store_data),
        .load_data  (w_load_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_stallreq  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    w_stallreq  = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stallreq = 1'b1;
                if (bus_ack) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Result is held from rd_buf until mem_wb is free to take it.
                if (stall[4] == c_no_stop) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= c_zero_word;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= c_zero_word;
            r_rd_buf    <= c_zero_word;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_bus_sel   <= w_sel;
                        r_bus_wdata <= w_store_data;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_rd_buf  <= bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // mem_wb-facing outputs are combinational but forced to zero in reset.
    always_comb begin
        mem_wdata = c_zero_word;
        mem_wd    = c_nop_reg_addr;
        mem_wreg  = 1'b0;
        mem_hi    = c_zero_word;
        mem_lo    = c_zero_word;
        mem_whilo = 1'b0;
        stallreq  = 1'b0;
        if (rst) begin
            mem_wdata = w_is_load ? w_load_data : wdata_i;
            mem_wd    = wd_i;
            mem_wreg  = w_is_store ? 1'b0 : wreg_i;
            mem_hi    = hi_i;
            mem_lo    = lo_i;
            mem_whilo = whilo_i;
            stallreq  = w_stallreq;
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_sel   = r_bus_sel;
    assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu. It applies table-driven
//               pass-through and load/store vectors, then hand-written reset
//               and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i;
    logic [5:0]  stall;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_whilo;
    logic        stallreq;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_LB  = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4, OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .stall(stall),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .mem_wdata(mem_wdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_whilo(mem_whilo), .stallreq(stallreq), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } pass_t;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          ack_cyc;     // cycle (op = cycle 0) in which ack is given
        int          hold_extra;  // extra HOLD cycles with stall[4] = Stop
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_wdata;   // bus_wdata for stores, mem_wdata for loads
    } txn_t;

    task automatic drive_nop();
        aluop_i = OP_ADD; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        mem_addr_i = 32'h0; reg2_i = 32'h0; bus_ack = 1'b0; stall = 6'b0;
    endtask

    // Entered and left at posedge + 1.
    task automatic run_txn(input txn_t t);
        int   n_req   = 0;
        int   n_stall = 0;
        int   last    = t.ack_cyc + 1 + t.hold_extra;
        logic prev_req;
        logic in_hold;
        logic ld;
        ld       = (t.op == OP_LB) || (t.op == OP_LBU) || (t.op == OP_LH) ||
                   (t.op == OP_LHU) || (t.op == OP_LW);
        prev_req = bus_req;
        for (int c = 0; c <= last; c++) begin
            aluop_i = t.op; mem_addr_i = t.addr; reg2_i = t.reg2;
            wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h5555_0000;
            in_hold   = (c > t.ack_cyc);
            // In HOLD the bus shows different data and a stray ack; both must be ignored.
            bus_rdata = in_hold ? ~t.rdata : t.rdata;
            bus_ack   = (c == t.ack_cyc) || in_hold;
            stall     = (in_hold && c < last) ? 6'b01_0000 : 6'b0;
            @(negedge clk);
            if (stallreq) n_stall++;
            if (bus_req && !prev_req) n_req++;
            prev_req = bus_req;
            if (c == 0) chk({t.name, " bus_req@op"}, {31'h0, bus_req}, 32'h0);
            if (c == 1) begin
                chk({t.name, " bus_addr"}, bus_addr, t.exp_addr);
                chk({t.name, " bus_sel"}, {28'h0, bus_sel}, {28'h0, t.exp_sel});
                chk({t.name, " bus_we"}, {31'h0, bus_we}, {31'h0, t.exp_we});
                if (!ld) chk({t.name, " bus_wdata"}, bus_wdata, t.exp_wdata);
            end
            if (in_hold) begin
                chk({t.name, " hold bus_req"}, {31'h0, bus_req}, 32'h0);
                chk({t.name, " hold bus_we"}, {31'h0, bus_we}, 32'h0);
                chk({t.name, " hold mem_wd"}, {27'h0, mem_wd}, 32'd7);
                chk({t.name, " hold mem_wreg"}, {31'h0, mem_wreg}, {31'h0, ld});
                if (ld) chk({t.name, " hold mem_wdata"}, mem_wdata, t.exp_wdata);
            end
            @(posedge clk); #1;
        end
        chk({t.name, " req pulses"}, n_req, 32'd1);
        chk({t.name, " stallreq cycles"}, n_stall, t.ack_cyc + 1);
        bus_ack = 1'b0;
        stall   = 6'b0;
    endtask

    task automatic check_idle(input string name);
        drive_nop();
        @(negedge clk);
        chk({name, " idle stallreq"}, {31'h0, stallreq}, 32'h0);
        chk({name, " idle bus_req"}, {31'h0, bus_req}, 32'h0);
        @(posedge clk); #1;
    endtask

    pass_t pv[4];
    txn_t  tv[9];
    txn_t  t;

    initial begin
        pv[0] = '{OP_ADD, 5'd3,  1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0};
        pv[1] = '{OP_ADD, 5'd31, 1'b0, 32'hFFFF_0001, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1};
        pv[2] = '{8'hE2,  5'd9,  1'b1, 32'h8000_0000, 32'h1, 32'h2, 1'b0};
        pv[3] = '{8'h00,  5'd1,  1'b1, 32'hCAFE_F00D, 32'h3, 32'h4, 1'b1};

        tv[0] = '{"LB",  OP_LB,  32'h101, 32'h0,         32'h11F2_3344, 2, 0, 32'h100, 4'b0100, 1'b0, 32'hFFFF_FFF2};
        tv[1] = '{"LHU", OP_LHU, 32'h202, 32'h0,         32'hAAAA_8001, 1, 0, 32'h200, 4'b0011, 1'b0, 32'h0000_8001};
        tv[2] = '{"LH",  OP_LH,  32'h202, 32'h0,         32'hAAAA_8001, 1, 0, 32'h200, 4'b0011, 1'b0, 32'hFFFF_8001};
        tv[3] = '{"SB",  OP_SB,  32'h003, 32'hDEAD_BE7F, 32'h0,         1, 2, 32'h000, 4'b0001, 1'b1, 32'h7F7F_7F7F};
        tv[4] = '{"SH",  OP_SH,  32'h002, 32'h1234_ABCD, 32'h0,         3, 1, 32'h000, 4'b0011, 1'b1, 32'hABCD_ABCD};
        tv[5] = '{"SW",  OP_SW,  32'h007, 32'h0BAD_F00D, 32'h0,         1, 0, 32'h004, 4'b1111, 1'b1, 32'h0BAD_F00D};
        tv[6] = '{"LBU", OP_LBU, 32'h100, 32'h0,         32'h80FF_0000, 1, 0, 32'h100, 4'b1000, 1'b0, 32'h0000_0080};
        tv[7] = '{"LB2", OP_LB,  32'h102, 32'h0,         32'h0000_8000, 2, 1, 32'h100, 4'b0010, 1'b0, 32'hFFFF_FF80};
        tv[8] = '{"LW",  OP_LW,  32'h013, 32'h0,         32'hCAFE_BABE, 1, 0, 32'h010, 4'b1111, 1'b0, 32'hCAFE_BABE};

        // Reset with non-zero inputs: every output must still read zero.
        rst = 1'b0; bus_rdata = 32'h0;
        drive_nop();
        aluop_i = OP_LW; wdata_i = 32'h1234; wd_i = 5'd5; wreg_i = 1'b1;
        hi_i = 32'h1111; lo_i = 32'h2222; whilo_i = 1'b1;
        #12;
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst mem_wd", {27'h0, mem_wd}, 32'h0);
        chk("rst mem_hi", mem_hi, 32'h0);
        chk("rst mem_whilo", {31'h0, mem_whilo}, 32'h0);
        chk("rst stallreq", {31'h0, stallreq}, 32'h0);
        chk("rst bus_req", {31'h0, bus_req}, 32'h0);
        @(posedge clk); #1;
        drive_nop();
        rst = 1'b1;
        @(posedge clk); #1;

        // Non-memory pass-through, checked in the same cycle.
        for (int i = 0; i < 4; i++) begin
            aluop_i = pv[i].op; wd_i = pv[i].wd; wreg_i = pv[i].wreg; wdata_i = pv[i].wdata;
            hi_i = pv[i].hi; lo_i = pv[i].lo; whilo_i = pv[i].whilo;
            bus_ack = (i == 1);  // ack in IDLE must be ignored
            #1;
            chk("pass mem_wdata", mem_wdata, pv[i].wdata);
            chk("pass mem_wd", {27'h0, mem_wd}, {27'h0, pv[i].wd});
            chk("pass mem_wreg", {31'h0, mem_wreg}, {31'h0, pv[i].wreg});
            chk("pass mem_hi", mem_hi, pv[i].hi);
            chk("pass mem_lo", mem_lo, pv[i].lo);
            chk("pass mem_whilo", {31'h0, mem_whilo}, {31'h0, pv[i].whilo});
            chk("pass stallreq", {31'h0, stallreq}, 32'h0);
            @(negedge clk);
            chk("pass bus_req", {31'h0, bus_req}, 32'h0);
            @(posedge clk); #1;
        end
        drive_nop();
        check_idle("pass");

        // Table of load/store transactions.
        for (int i = 0; i < 9; i++) begin
            run_txn(tv[i]);
            check_idle(tv[i].name);
        end

        // Reset asserted while BUSY abandons the transfer at once.
        aluop_i = OP_LW; mem_addr_i = 32'h80; wd_i = 5'd4; wreg_i = 1'b1;
        wdata_i = 32'h7777; hi_i = 32'h1111; lo_i = 32'h2222; whilo_i = 1'b1;
        @(posedge clk); #1;
        chk("busy bus_req", {31'h0, bus_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("midrst bus_req", {31'h0, bus_req}, 32'h0);
        chk("midrst bus_addr", bus_addr, 32'h0);
        chk("midrst bus_sel", {28'h0, bus_sel}, 32'h0);
        chk("midrst stallreq", {31'h0, stallreq}, 32'h0);
        chk("midrst mem_lo", mem_lo, 32'h0);
        chk("midrst mem_wreg", {31'h0, mem_wreg}, 32'h0);
        drive_nop();
        @(posedge clk); #1;
        rst = 1'b1;
        check_idle("post-rst");
        t = '{"LW40", OP_LW, 32'h040, 32'h0, 32'h1357_9BDF, 1, 0, 32'h040, 4'b1111, 1'b0, 32'h1357_9BDF};
        run_txn(t);
        check_idle("LW40");

        // Back-to-back loads with no idle gap between them.
        t = '{"LW10", OP_LW, 32'h010, 32'h0, 32'hA1A2_A3A4, 1, 0, 32'h010, 4'b1111, 1'b0, 32'hA1A2_A3A4};
        run_txn(t);
        t = '{"LW14", OP_LW, 32'h014, 32'h0, 32'hB1B2_B3B4, 2, 0, 32'h014, 4'b1111, 1'b0, 32'hB1B2_B3B4};
        run_txn(t);
        check_idle("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
